// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared widths, default requester count and controller state encoding.
package mult_share_pkg;
   localparam int OP_W        = 8;
   localparam int PROD_W      = 16;
   localparam int DEF_NUM_REQ = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_t;
endpackage

// File: rtl/mult_share_rr_arb.sv
// mult_share_rr_arb: round-robin one-hot grant; the pointer holds the index the next search starts from.
module mult_share_rr_arb
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_idx_hi;
   logic [ID_W-1:0] w_idx_lo;
   logic            w_hit_hi;
   // Lowest request at or above the pointer wins; otherwise wrap to the lowest request overall.
   always_comb begin
      w_hit_hi = 1'b0;
      w_idx_hi = '0;
      o_any    = 1'b0;
      w_idx_lo = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (i_req[j] && ID_W'(j) >= r_ptr) begin
            w_hit_hi = 1'b1;
            w_idx_hi = ID_W'(j);
         end
         if (i_req[j]) begin
            o_any    = 1'b1;
            w_idx_lo = ID_W'(j);
         end
      end
      o_idx   = w_hit_hi ? w_idx_hi : w_idx_lo;
      o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (i_accept && o_any)
         r_ptr <= (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + ID_W'(1);
   end
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one external sequential 8x8 signed multiplier among NUM_REQ requesters.
// Define MULT_SHARE_ZERO_BYPASS_EN to answer zero-operand requests directly from IDLE.
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*OP_W-1:0] req_mc,
   input  logic [NUM_REQ*OP_W-1:0] req_mp,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [PROD_W-1:0]       rsp_prod,
   output logic                    mul_load,
   output logic                    mul_start,
   output logic [OP_W-1:0]         mul_mc,
   output logic [OP_W-1:0]         mul_mp,
   input  logic [PROD_W-1:0]       mul_prod,
   input  logic                    mul_done
);
   state_t              r_state;
   state_t              w_next;
   logic [OP_W-1:0]     r_mc;
   logic [OP_W-1:0]     r_mp;
   logic [ID_W-1:0]     r_id;
   logic [PROD_W-1:0]   r_prod;
   logic [OP_W-1:0]     w_sel_mc;
   logic [OP_W-1:0]     w_sel_mp;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic                w_any;
   logic                w_accept;

   mult_share_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (req_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

   always_comb begin
      w_sel_mc = '0;
      w_sel_mp = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (w_grant[k]) begin
            w_sel_mc = req_mc[k*OP_W +: OP_W];
            w_sel_mp = req_mp[k*OP_W +: OP_W];
         end
   end

`ifdef MULT_SHARE_ZERO_BYPASS_EN
   logic w_zero;
   assign w_zero = (w_sel_mc == '0) || (w_sel_mp == '0);
`endif

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      req_ready = '0;
      mul_load  = 1'b0;
      mul_start = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_accept  = w_any && rst_n;
            req_ready = rst_n ? w_grant : '0;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
            if (w_any) w_next = w_zero ? ST_RESP : ST_LOAD;
`else
            if (w_any) w_next = ST_LOAD;
`endif
         end
         ST_LOAD: begin
            mul_load = 1'b1;
            w_next   = ST_RUN;
         end
         ST_RUN: begin
            mul_start = !mul_done;
            if (mul_done) w_next = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mc    <= '0;
         r_mp    <= '0;
         r_id    <= '0;
         r_prod  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mc <= w_sel_mc;
            r_mp <= w_sel_mp;
            r_id <= w_idx;
         end
         if (r_state == ST_RUN && mul_done) r_prod <= mul_prod;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
         if (w_accept && w_zero) r_prod <= '0;
`endif
      end
   end

   assign mul_mc   = r_mc;
   assign mul_mp   = r_mp;
   assign rsp_id   = r_id;
   assign rsp_prod = r_prod;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed bench with a latency/round-robin reference model and a stub multiplier engine.
module tb_mult_share_ctrl;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*8-1:0] req_mc = '0;
   logic [N*8-1:0] req_mp = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [1:0]     rsp_id;
   logic [15:0]    rsp_prod;
   logic           mul_load, mul_start, mul_done;
   logic [7:0]     mul_mc, mul_mp;
   logic [15:0]    mul_prod;
   int             n_err = 0;
   int             n_chk = 0;
   int             cyc = 0;
   bit             chk_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_share_ctrl #(.NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mc(req_mc), .req_mp(req_mp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
      .mul_load(mul_load), .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
      .mul_prod(mul_prod), .mul_done(mul_done)
   );

   // Engine stub: product ready after 8 start steps, done masked while loading.
   int          e_cnt = 0;
   logic [15:0] e_prod = '0;
   always @(posedge clk)
      if (mul_load) begin
         e_cnt  <= 0;
         e_prod <= {{8{mul_mc[7]}}, mul_mc} * {{8{mul_mp[7]}}, mul_mp};
      end else if (mul_start)
         e_cnt <= e_cnt + 1;
   assign mul_done = (e_cnt == 8) && !mul_load;
   assign mul_prod = e_prod;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction
   function automatic logic [7:0] op(input logic [N*8-1:0] v, input int i);
      return v[i*8 +: 8];
   endfunction
   function automatic int smul(input logic [7:0] a, input logic [7:0] b);
      return int'($signed(a)) * int'($signed(b));
   endfunction

   // Model: m_age counts cycles since acceptance (1 = load cycle), m_resp marks a pending response.
   int        m_age = 0, m_ptr = 0, m_id = 0, m_prod = 0, m_g;
   bit        m_resp = 1'b0;
   logic [7:0] m_mc = '0, m_mp = '0;
   logic      idle_grant;
   always_comb m_g = pick(req_valid, m_ptr);
   assign idle_grant = rst_n && !m_resp && m_age == 0 && m_g >= 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_age <= 0; m_resp <= 1'b0; m_ptr <= 0;
      end else if (m_resp) begin
         if (rsp_ready) m_resp <= 1'b0;
      end else if (m_age == 10) begin
         m_age <= 0; m_resp <= 1'b1;
      end else if (m_age > 0)
         m_age <= m_age + 1;
      else if (m_g >= 0) begin
         m_id   <= m_g;
         m_mc   <= op(req_mc, m_g);
         m_mp   <= op(req_mp, m_g);
         m_prod <= smul(op(req_mc, m_g), op(req_mp, m_g));
         m_ptr  <= (m_g + 1) % N;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
         if (op(req_mc, m_g) == 0 || op(req_mp, m_g) == 0) m_resp <= 1'b1;
         else m_age <= 1;
`else
         m_age <= 1;
`endif
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk)
      if (chk_en) begin
         check("req_ready", int'(req_ready), idle_grant ? (1 << m_g) : 0);
         check("rsp_valid", int'(rsp_valid), int'(m_resp));
         check("mul_load", int'(mul_load), int'(m_age == 1));
         check("mul_start", int'(mul_start), int'(m_age >= 2 && m_age <= 9));
         if (m_resp) begin
            check("rsp_id", int'(rsp_id), m_id);
            check("rsp_prod", int'($signed(rsp_prod)), m_prod);
         end
         if (m_age == 1) begin
            check("mul_mc", int'(mul_mc), int'(m_mc));
            check("mul_mp", int'(mul_mp), int'(m_mp));
         end
      end

   task automatic set_op(input int i, input int mc, input int mp);
      req_mc[i*8 +: 8] = 8'(mc);
      req_mp[i*8 +: 8] = 8'(mp);
   endtask

   task automatic wait_rsp(input string name, input int t0, input int lat, input int id, input int prod);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (rsp_valid !== 1'b1 && k < 40);
      if (rsp_valid !== 1'b1) begin
         n_chk++;
         n_err++;
         $display("FAIL %s_timeout: got no rsp_valid, expected one within 40 cycles", name);
      end else begin
         check({name, "_lat"}, cyc - t0, lat);
         check({name, "_id"}, int'(rsp_id), id);
         check({name, "_prod"}, int'($signed(rsp_prod)), prod);
      end
   endtask

   task automatic run_one(input string name, input int id, input int mc, input int mp, input int lat, input int prod);
      int t0;
      set_op(id, mc, mp);
      req_valid = 4'(1 << id);
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(name, t0, lat, id, prod);
      @(posedge clk); #1;
   endtask

   localparam int ORDER [5] = '{0, 1, 2, 3, 0};
   localparam int CPROD [4] = '{12, -30, 10000, 128};

   initial begin
      int t0;
      int zlat;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
      zlat = 1;
`else
      zlat = 11;
`endif
      req_valid = 4'b0101;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_mul_load", int'(mul_load), 0);
      check("rst_mul_start", int'(mul_start), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_prod", int'(rsp_prod), 0);
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_one("single", 0, 7, -3, 11, -21);
      run_one("ext_mm", 1, -128, -128, 11, 16384);
      run_one("ext_pm", 2, 127, -128, 11, -16256);
      run_one("zero", 3, 0, 55, zlat, 0);

      // Backpressure with requester 3 waiting behind requester 2.
      rsp_ready = 1'b0;
      set_op(2, -7, 9);
      set_op(3, 5, 5);
      req_valid = 4'b0100;
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = 4'b1000;
      wait_rsp("bp", t0, 11, 2, -63);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", int'(rsp_valid), 1);
         check("bp_prod", int'($signed(rsp_prod)), -63);
         check("bp_id", int'(rsp_id), 2);
         check("bp_ready", int'(req_ready), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      @(negedge clk);
      check("bp_one_handshake", int'(rsp_valid), 0);
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp("bp_next", t0, 11, 3, 25);
      @(posedge clk); #1;

      // Contention from reset: all four held valid.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_op(0, 3, 4);
      set_op(1, -5, 6);
      set_op(2, 100, 100);
      set_op(3, -1, -128);
      req_valid = 4'hF;
      t0 = cyc;
      for (int n = 0; n < 5; n++) begin
         wait_rsp("cont", t0, 11, ORDER[n], CPROD[ORDER[n]]);
         @(posedge clk); #1;
         if (n == 4) req_valid = '0;
         t0 = cyc;
      end
      @(posedge clk); #1;

      // Reset in the middle of RUN.
      set_op(1, 9, 9);
      req_valid = 4'b0010;
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rsp_valid", int'(rsp_valid), 0);
      check("mid_mul_load", int'(mul_load), 0);
      check("mid_mul_start", int'(mul_start), 0);
      check("mid_req_ready", int'(req_ready), 0);
      check("mid_rsp_id", int'(rsp_id), 0);
      check("mid_rsp_prod", int'(rsp_prod), 0);
      @(posedge clk); #1;
      set_op(1, 10, -10);
      set_op(3, 2, 2);
      req_valid = 4'b1010;
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp("after_rst", t0, 11, 1, -100);
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sequential 8x8 signed Booth multiplier engine.
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of the requester ID.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_mc  input  NUM_REQ*8  signed multiplicands, requester i in bits [8i+7:8i].
REQ-008 req_mp  input  NUM_REQ*8  signed multipliers, same packing.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  ID_W  index of the requester that owns the result.
REQ-012 rsp_prod  output  16  signed product.
REQ-013 mul_load / mul_start  output  1 each  engine load and step controls.
REQ-014 mul_mc / mul_mp  output  8 each  engine operands, driven from internal registers.
REQ-015 mul_prod  input  16 / mul_done  input  1  engine product and completion flag (done = 8 steps taken, forced 0 during load).

Function
REQ-016 FSM states: IDLE, LOAD, RUN, RESP; encoding from the shared package.
REQ-017 IDLE: when any req_valid is high, the arbiter grants one requester; req_ready[g] is high combinationally that cycle; operands and ID are captured; next state LOAD.
REQ-018 Arbitration is round-robin: search starts at the index after the last grant; the pointer updates only on an accepted request.
REQ-019 req_ready is 0 in every state other than IDLE.
REQ-020 LOAD: mul_load=1 for exactly one cycle; next state RUN.
REQ-021 RUN: mul_start = !mul_done; when mul_done=1, capture mul_prod into rsp_prod and go to RESP. mul_start is never high in the same cycle as mul_done.
REQ-022 RESP: rsp_valid=1; rsp_prod and rsp_id are stable until rsp_valid && rsp_ready, then IDLE. No new grant occurs in the handshake cycle.
REQ-023 Latency: accept at cycle T gives mul_load at T+1, mul_start at T+2..T+9, and rsp_valid at T+11 with rsp_ready held high.
REQ-024 Requests held high while not granted are served in round-robin order; no requester waits more than NUM_REQ operations.
REQ-025 Products are full 16-bit signed; (-128)*(-128)=16384 is exact.

Reset
REQ-026 rst_n=0 at a clock edge forces IDLE, rsp_valid=0, mul_load=0, mul_start=0, req_ready=0, rsp_id=0, rsp_prod=0, and RR pointer to requester 0, including mid-RUN; the in-flight operation is discarded.
REQ-027 The first grant after reset goes to the lowest-indexed valid requester.

Configuration
REQ-028 Macro MULT_SHARE_ZERO_BYPASS_EN: when defined, a granted request with mc==0 or mp==0 skips LOAD/RUN, goes IDLE->RESP, and returns rsp_prod=0 with rsp_valid at T+1.
REQ-029 Without MULT_SHARE_ZERO_BYPASS_EN, every request goes through LOAD and RUN with the REQ-023 latency.

Structure
REQ-030 Package mult_share_pkg holds OP_W=8, PROD_W=16, the default NUM_REQ, and the state enum typedef.
REQ-031 A sub-module mult_share_rr_arb (NUM_REQ-wide round-robin one-hot grant with pointer) is instantiated once.
REQ-032 The multiplier engine is external; this block contains no arithmetic beyond the zero-detect.

Verification
REQ-033 Single request: req 0 mc=7, mp=-3, rsp_ready=1 -> rsp_valid at T+11, rsp_prod=-21, rsp_id=0.
REQ-034 Contention: reqs 0..3 all valid from reset -> grants in order 0,1,2,3,0; each rsp_id matches its operands.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_prod, and rsp_id stay stable, req_ready stays 0, then one handshake.
REQ-036 Extremes: mc=-128, mp=-128 -> 16384; mc=127, mp=-128 -> -16256.
REQ-037 Reset mid-RUN: rst_n low at T+5 -> all outputs at reset values next cycle; a new request then completes correctly.
REQ-038 With MULT_SHARE_ZERO_BYPASS_EN: mc=0, mp=55 -> rsp_prod=0 at T+1, mul_load never asserted; without the macro -> rsp_prod=0 at T+11.
